reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file with one synchronous write port and a per-register busy scoreboard.
- Sits in the CPU decode/writeback path.
  - Decode reads operands and reserves the destination register.
  - Writeback writes the result and clears the reservation.
- Reads are registered: one-cycle latency, per-port enable and valid.
- Busy status is returned with each read so decode can stall on RAW hazards.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port 1-cycle pulse: rd_data for that port updated this cycle
- rd_busy  out  NUM_RD  per-port busy bit of the addressed register, captured with the read
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (mark busy) request
- rsv_addr  in  ADDR_W  register to reserve
- busy_vec  out  DEPTH  live scoreboard, bit r = register r busy
- rsv_err  out  1  1-cycle pulse: reserve of an already-busy register

Behaviour:
- Reset (rst=1, async, any time including mid-operation):
  - all DEPTH registers = 0, busy_vec = 0, rd_data = 0, rd_valid = 0, rd_busy = 0, rsv_err = 0.
  - In-flight reservations and writes are discarded.
  - First functional edge is the first rising clk with rst=0.
- Write:
  - wr_en=1 at posedge: mem[wr_addr] <= wr_data.
  - Same posedge clears busy[wr_addr], unless the reserve rule below keeps it set.
  - Writing a non-busy register is legal; busy stays 0.
- Reserve:
  - rsv_en=1 at posedge: busy[rsv_addr] <= 1.
  - Same-cycle write and reserve to the same address: data written, busy ends 1 (reserve wins; a new producer follows the retiring one).
  - rsv_err pulses 1 for one cycle when busy[rsv_addr] was already 1 and is not being cleared by a same-cycle write to that address. busy remains 1 either way.
- Read, per port i, independent:
  - rd_en[i]=1 at posedge: next cycle rd_data[i] = mem[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]], rd_valid[i] = 1.
  - rd_en[i]=0: rd_data[i] and rd_busy[i] hold their values, rd_valid[i] = 0.
  - Several ports reading the same address in the same cycle all return identical data.
- Read/write collision (same address, same cycle): result defined by the optional feature below.
- A reserve in the same cycle as a read of that address does not affect the returned rd_busy; the read sees the pre-edge busy.
- busy_vec is a direct register output with no combinational path from inputs.
- No backpressure; every request completes in one cycle.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined (write-first forwarding): if wr_en=1 and rd_en[i]=1 with rd_addr[i]==wr_addr in the same cycle:
  - rd_data[i] next cycle = wr_data;
  - rd_busy[i] = 0, unless a same-cycle reserve also targets that address, in which case 1.
- Undefined (read-first):
  - rd_data[i] = old mem contents;
  - rd_busy[i] = old busy bit.
- Scoreboard and write behaviour are identical in both builds.

Test Plan:
- Reset/defaults: assert rst mid-stream after writing r3=0xDEAD -> immediately rd_data=0, busy_vec=0, rd_valid=0. After release, read r3 -> 0x0000_0000, rd_valid pulses 1 cycle later.
- Basic write/read, NUM_RD=2:
  - write r5=0x1234_5678, r6=0xCAFE_F00D;
  - next cycle read port0 r5, port1 r6 -> one cycle later rd_data0=0x12345678, rd_data1=0xCAFEF00D, rd_valid=2'b11; then rd_en=0 -> data held, rd_valid=0.
- Scoreboard:
  - reserve r7 -> busy_vec[7]=1; read r7 -> rd_busy=1;
  - write r7=0x42 -> busy_vec[7]=0;
  - reserve r7 twice without a write -> second reserve gives rsv_err pulse of exactly 1 cycle.
- Same-cycle write+reserve r2 (busy=1 beforehand) -> mem[2] updated, busy_vec[2]=1, rsv_err=0.
- Collision:
  - r9 holds 0x11; same cycle write r9=0x22 and read r9 on both ports;
  - expect 0x22 with rd_busy=0 when REG_FILE_BYPASS_EN is defined, 0x11 otherwise;
  - a following read returns 0x22 in both builds.
- Parameter sweep: DATA_W=16, ADDR_W=5, NUM_RD=3 -> write r31=0xBEEF, read r31 on all three ports -> all return 0xBEEF; busy_vec width is 32.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with one write port and a per-register busy scoreboard.
// Optional write-first forwarding on read/write collisions: define REG_FILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2,
    localparam int DEPTH = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy_vec,
    output logic                     rsv_err
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic              rsv_err_reg;
    logic              rsv_err_next;
    logic              wr_clears_rsv;

    // Register array is fully reset, so it maps to flops rather than block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_reg[r] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign wr_clears_rsv = wr_en && (wr_addr == rsv_addr);

    // Reserve is applied after the write clear, so a new producer wins over a retiring one.
    always_comb begin
        busy_next = busy_reg;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_next[rsv_addr] = 1'b1;
        end
        rsv_err_next = rsv_en && busy_reg[rsv_addr] && !wr_clears_rsv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg    <= '0;
            rsv_err_reg <= 1'b0;
        end else begin
            busy_reg    <= busy_next;
            rsv_err_reg <= rsv_err_next;
        end
    end

    assign busy_vec = busy_reg;
    assign rsv_err  = rsv_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
            logic [ADDR_W-1:0] port_addr;
            logic [DATA_W-1:0] rd_data_reg;
            logic [DATA_W-1:0] rd_data_next;
            logic              rd_busy_reg;
            logic              rd_busy_next;
            logic              rd_valid_reg;
            logic              bypass_hit;

            assign port_addr = rd_addr[gi*ADDR_W +: ADDR_W];

`ifdef REG_FILE_BYPASS_EN
            assign bypass_hit = wr_en && (wr_addr == port_addr);
`else
            assign bypass_hit = 1'b0;
`endif

            // Without forwarding, reads see the pre-edge contents and busy bit.
            always_comb begin
                rd_data_next = rd_data_reg;
                rd_busy_next = rd_busy_reg;
                if (rd_en[gi]) begin
                    if (bypass_hit) begin
                        rd_data_next = wr_data;
                        rd_busy_next = rsv_en && (rsv_addr == wr_addr);
                    end else begin
                        rd_data_next = mem_reg[port_addr];
                        rd_busy_next = busy_reg[port_addr];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg  <= '0;
                    rd_busy_reg  <= 1'b0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_data_reg  <= rd_data_next;
                    rd_busy_reg  <= rd_busy_next;
                    rd_valid_reg <= rd_en[gi];
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
            assign rd_busy[gi]                  = rd_busy_reg;
            assign rd_valid[gi]                 = rd_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance plus a 16-bit/32-entry/3-port instance.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic [15:0] busy_vec;
    logic        rsv_err;

    logic [2:0]  b_rd_en;
    logic [14:0] b_rd_addr;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_valid;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        b_rsv_en;
    logic [4:0]  b_rsv_addr;
    logic [31:0] b_busy_vec;
    logic        b_rsv_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec), .rsv_err(rsv_err)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) dut_b (
        .clk(clk), .rst(rst),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .busy_vec(b_busy_vec), .rsv_err(b_rsv_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = 1'b0; rsv_en = 1'b0;
        b_rd_en = '0; b_wr_en = 1'b0; b_rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_DEAD;
        rsv_en = 1'b1; rsv_addr = 4'd4;
        tick();
        idle();
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        tick();
        n_checks++;
        if (rd_data[31:0] !== 32'h0000_DEAD) begin
            n_fail++; $display("FAIL pre_reset_read: got %h expected %h", rd_data[31:0], 32'h0000_DEAD);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rd_data !== 64'h0 || busy_vec !== 16'h0 || rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: rd_data=%h busy_vec=%h rd_valid=%b expected all zero", rd_data, busy_vec, rd_valid);
        end
        idle();
        tick();
        rst = 1'b0;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        n_checks++;
        if (rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL valid_before_read: got %b expected 00", rd_valid);
        end
        tick();
        n_checks++;
        if (rd_data[31:0] !== 32'h0 || rd_valid !== 2'b01) begin
            n_fail++; $display("FAIL read_after_reset: data=%h valid=%b expected 00000000 01", rd_data[31:0], rd_valid);
        end
        idle();
        $display("test_reset done");
    endtask

    task automatic test_basic_rw();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234_5678;
        tick();
        wr_addr = 4'd6; wr_data = 32'hCAFE_F00D;
        tick();
        idle();
        rd_en = 2'b11; rd_addr = {4'd6, 4'd5};
        tick();
        n_checks++;
        if (rd_data !== 64'hCAFE_F00D_1234_5678 || rd_valid !== 2'b11) begin
            n_fail++; $display("FAIL basic_read: data=%h valid=%b expected cafef00d12345678 11", rd_data, rd_valid);
        end
        rd_en = 2'b00; rd_addr = {4'd0, 4'd0};
        tick();
        n_checks++;
        if (rd_data !== 64'hCAFE_F00D_1234_5678 || rd_valid !== 2'b00) begin
            n_fail++; $display("FAIL read_hold: data=%h valid=%b expected cafef00d12345678 00", rd_data, rd_valid);
        end
        $display("test_basic_rw done");
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 4'd7;
        tick();
        idle();
        n_checks++;
        if (busy_vec[7] !== 1'b1 || rsv_err !== 1'b0) begin
            n_fail++; $display("FAIL reserve_r7: busy7=%b err=%b expected 1 0", busy_vec[7], rsv_err);
        end
        rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
        tick();
        idle();
        n_checks++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL read_busy_r7: got %b expected 1", rd_busy[0]);
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h42;
        tick();
        idle();
        n_checks++;
        if (busy_vec[7] !== 1'b0) begin
            n_fail++; $display("FAIL write_clears_r7: got %b expected 0", busy_vec[7]);
        end
        rsv_en = 1'b1; rsv_addr = 4'd7;
        tick();
        n_checks++;
        if (rsv_err !== 1'b0) begin
            n_fail++; $display("FAIL first_reserve_err: got %b expected 0", rsv_err);
        end
        tick();
        idle();
        n_checks++;
        if (rsv_err !== 1'b1 || busy_vec[7] !== 1'b1) begin
            n_fail++; $display("FAIL double_reserve_err: err=%b busy7=%b expected 1 1", rsv_err, busy_vec[7]);
        end
        tick();
        n_checks++;
        if (rsv_err !== 1'b0) begin
            n_fail++; $display("FAIL rsv_err_one_cycle: got %b expected 0", rsv_err);
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h43;
        tick();
        idle();
        $display("test_scoreboard done");
    endtask

    task automatic test_write_reserve();
        rsv_en = 1'b1; rsv_addr = 4'd2;
        tick();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0077;
        tick();
        idle();
        n_checks++;
        if (busy_vec[2] !== 1'b1 || rsv_err !== 1'b0) begin
            n_fail++; $display("FAIL write_reserve_r2: busy2=%b err=%b expected 1 0", busy_vec[2], rsv_err);
        end
        rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
        tick();
        idle();
        n_checks++;
        if (rd_data[31:0] !== 32'h77 || rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL write_reserve_data: data=%h busy=%b expected 00000077 1", rd_data[31:0], rd_busy[0]);
        end
        // Read concurrent with a reserve sees the pre-edge busy bit.
        rsv_en = 1'b1; rsv_addr = 4'd11;
        rd_en = 2'b10; rd_addr = {4'd11, 4'd0};
        tick();
        idle();
        n_checks++;
        if (rd_busy[1] !== 1'b0 || busy_vec[11] !== 1'b1) begin
            n_fail++; $display("FAIL read_vs_reserve: rd_busy=%b busy11=%b expected 0 1", rd_busy[1], busy_vec[11]);
        end
        $display("test_write_reserve done");
    endtask

    task automatic test_collision();
        logic [63:0] exp_data;
        logic [31:0] exp_d0;
        logic        exp_b0;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        rd_en = 2'b11; rd_addr = {4'd9, 4'd9};
`ifdef REG_FILE_BYPASS_EN
        exp_data = {32'h22, 32'h22};
`else
        exp_data = {32'h11, 32'h11};
`endif
        tick();
        idle();
        n_checks++;
        if (rd_data !== exp_data || rd_busy !== 2'b00) begin
            n_fail++; $display("FAIL collision_read: data=%h busy=%b expected %h 00", rd_data, rd_busy, exp_data);
        end
        rd_en = 2'b11; rd_addr = {4'd9, 4'd9};
        tick();
        idle();
        n_checks++;
        if (rd_data !== {32'h22, 32'h22}) begin
            n_fail++; $display("FAIL post_collision_read: data=%h expected 0000002200000022", rd_data);
        end
        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 32'h33;
        rsv_en = 1'b1; rsv_addr = 4'd10;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd10};
`ifdef REG_FILE_BYPASS_EN
        exp_d0 = 32'h33; exp_b0 = 1'b1;
`else
        exp_d0 = 32'h0;  exp_b0 = 1'b0;
`endif
        tick();
        idle();
        n_checks++;
        if (rd_data[31:0] !== exp_d0 || rd_busy[0] !== exp_b0) begin
            n_fail++; $display("FAIL collision_with_reserve: data=%h busy=%b expected %h %b", rd_data[31:0], rd_busy[0], exp_d0, exp_b0);
        end
        $display("test_collision done");
    endtask

    task automatic test_param_sweep();
        b_wr_en = 1'b1; b_wr_addr = 5'd31; b_wr_data = 16'hBEEF;
        tick();
        idle();
        b_rd_en = 3'b111; b_rd_addr = {5'd31, 5'd31, 5'd31};
        b_rsv_en = 1'b1; b_rsv_addr = 5'd31;
        tick();
        idle();
        n_checks++;
        if (b_rd_data !== {3{16'hBEEF}} || b_rd_valid !== 3'b111) begin
            n_fail++; $display("FAIL sweep_read: data=%h valid=%b expected beefbeefbeef 111", b_rd_data, b_rd_valid);
        end
        n_checks++;
        if (b_busy_vec !== 32'h8000_0000) begin
            n_fail++; $display("FAIL sweep_busy_vec: got %h expected 80000000", b_busy_vec);
        end
        $display("test_param_sweep done");
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic_rw();
        test_scoreboard();
        test_write_reserve();
        test_collision();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
